// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, score limits and
// default timing parameters.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_CRASH   = 2'd2,
    ST_RESTART = 2'd3
  } game_state_e;

  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 999;

  localparam int DEF_SCORE_DIV    = 32;
  localparam int DEF_CRASH_FRAMES = 120;
  localparam int DEF_FLASH_DIV    = 8;

  // Score increment that sticks at SCORE_MAX instead of running on to 1023.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score);
    if (score >= SCORE_W'(SCORE_MAX)) return SCORE_W'(SCORE_MAX);
    return score + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registers the active-low vertical sync and flags the first cycle in which the
// registered value has fallen: one pulse per frame, two cycles after iVS drops.
module frame_tick_gen (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic iVS,
  output logic frame_edge
);

  logic vs_q, vs_d;
  logic vs_prev_q, vs_prev_d;

  always_comb begin
    vs_d      = iVS;
    vs_prev_d = vs_q;
  end

  // Reset to the idle-high sync level so releasing reset never looks like a frame.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign frame_edge = vs_prev_q & ~vs_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-level control FSM: IDLE -> RESTART -> PLAY -> CRASH -> IDLE, with frame
// pacing from vertical sync, a saturating score and a crash blink flag.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SCORE_DIV    = DEF_SCORE_DIV,
  parameter int CRASH_FRAMES = DEF_CRASH_FRAMES,
  parameter int FLASH_DIV    = DEF_FLASH_DIV
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iVS,
  input  logic               iStart,
  input  logic               iCollision,
  output logic               oFrameTick,
  output logic               oMoveEn,
  output logic               oResetGame,
  output logic [1:0]         oState,
  output logic [SCORE_W-1:0] oScore,
  output logic               oFlash
);

  localparam int DIV_W = $clog2(SCORE_DIV + 1);
  localparam int CNT_W = $clog2(CRASH_FRAMES + 1);
  localparam int FL_W  = $clog2(FLASH_DIV + 1);

  logic frame_edge;
  logic start_edge;

  game_state_e        state_q, state_d;
  logic               start_q, start_d;
  logic               start_prev_q, start_prev_d;
  logic               grace_q, grace_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   crash_cnt_q, crash_cnt_d;
  logic [FL_W-1:0]    flash_div_q, flash_div_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               flash_q, flash_d;
  logic               tick_q, tick_d;
  logic               move_en_q, move_en_d;
  logic               reset_game_q, reset_game_d;

  frame_tick_gen u_frame_tick_gen (
    .iVGA_CLK   (iVGA_CLK),
    .iRST_n     (iRST_n),
    .iVS        (iVS),
    .frame_edge (frame_edge)
  );

  assign start_edge = start_q & ~start_prev_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    start_d      = iStart;
    start_prev_d = start_q;
    grace_d      = grace_q;
    div_d        = div_q;
    crash_cnt_d  = crash_cnt_q;
    flash_div_d  = flash_div_q;
    score_d      = score_q;
    flash_d      = flash_q;
    tick_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_RESTART;
      end

      ST_RESTART: begin
        score_d = '0;
        div_d   = '0;
        grace_d = 1'b1;
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        // Collision is only sampled on the frame edge; mid-frame glitches never reach here.
        if (frame_edge) begin
          tick_d = 1'b1;
          if (iCollision && !grace_q) begin
            state_d     = ST_CRASH;
            crash_cnt_d = CNT_W'(CRASH_FRAMES - 1);
            flash_div_d = '0;
            flash_d     = 1'b1;
          end else begin
            grace_d = 1'b0;
            if (div_q == DIV_W'(SCORE_DIV - 1)) begin
              div_d   = '0;
              score_d = score_inc(score_q);
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
      end

      ST_CRASH: begin
        if (frame_edge) begin
          if (crash_cnt_q == '0) begin
            state_d = ST_IDLE;
            flash_d = 1'b0;
          end else begin
            crash_cnt_d = crash_cnt_q - CNT_W'(1);
            if (flash_div_q == FL_W'(FLASH_DIV - 1)) begin
              flash_div_d = '0;
              flash_d     = ~flash_q;
            end else begin
              flash_div_d = flash_div_q + FL_W'(1);
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Decoded from the next state so these outputs line up with oState.
    move_en_d    = (state_d == ST_PLAY);
    reset_game_d = (state_d == ST_RESTART);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      grace_q      <= 1'b0;
      div_q        <= '0;
      crash_cnt_q  <= '0;
      flash_div_q  <= '0;
      score_q      <= '0;
      flash_q      <= 1'b0;
      tick_q       <= 1'b0;
      move_en_q    <= 1'b0;
      reset_game_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      grace_q      <= grace_d;
      div_q        <= div_d;
      crash_cnt_q  <= crash_cnt_d;
      flash_div_q  <= flash_div_d;
      score_q      <= score_d;
      flash_q      <= flash_d;
      tick_q       <= tick_d;
      move_en_q    <= move_en_d;
      reset_game_q <= reset_game_d;
    end
  end

  assign oState     = state_q;
  assign oFrameTick = tick_q;
  assign oMoveEn    = move_en_q;
  assign oResetGame = reset_game_q;
  assign oScore     = score_q;
  assign oFlash     = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: frame-tick scoreboard plus scenario
// tasks for start, scoring, collision, crash blink, grace and saturation.
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: short crash for a quick blink sequence.
  logic       rst_n, vs, start, col;
  logic       tick, move_en, reset_game, flash;
  logic [1:0] state;
  logic [9:0] score;

  game_sequencer #(.SCORE_DIV(32), .CRASH_FRAMES(4), .FLASH_DIV(2)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iStart(start), .iCollision(col),
    .oFrameTick(tick), .oMoveEn(move_en), .oResetGame(reset_game),
    .oState(state), .oScore(score), .oFlash(flash)
  );

  // Second instance scores on every frame so saturation is reachable quickly.
  logic       s_rst_n, s_vs, s_start, s_col;
  logic       s_tick, s_move_en, s_reset_game, s_flash;
  logic [1:0] s_state;
  logic [9:0] s_score;

  game_sequencer #(.SCORE_DIV(1), .CRASH_FRAMES(4), .FLASH_DIV(2)) dut_sat (
    .iVGA_CLK(clk), .iRST_n(s_rst_n), .iVS(s_vs), .iStart(s_start), .iCollision(s_col),
    .oFrameTick(s_tick), .oMoveEn(s_move_en), .oResetGame(s_reset_game),
    .oState(s_state), .oScore(s_score), .oFlash(s_flash)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_seen = 0;
  int exp_tick[$];

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: each expected tick cycle is queued when iVS is dropped.
  always @(negedge clk) begin
    if (tick) begin
      tick_seen = tick_seen + 1;
      checks = checks + 1;
      if (exp_tick.size() == 0) begin
        errors = errors + 1;
        $display("FAIL tick_unexpected at cycle %0d", cyc);
      end else begin
        int e;
        e = exp_tick.pop_front();
        if (cyc !== e) begin
          errors = errors + 1;
          $display("FAIL tick_latency got cycle=%0d exp cycle=%0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic drive_frame(input bit expect_tick);
    @(negedge clk);
    vs = 1'b0;
    if (expect_tick) exp_tick.push_back(cyc + 2);
    @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sat_frame();
    @(negedge clk);
    s_vs = 1'b0;
    @(negedge clk);
    s_vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b1; start = 1'b0; col = 1'b0;
    s_rst_n = 1'b0; s_vs = 1'b1; s_start = 1'b0; s_col = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({tick, move_en, reset_game, flash} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {tick, move_en, reset_game, flash}); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_after_release got=%0d exp=0", state); end
  endtask

  task automatic test_start();
    pulse_start();
    @(negedge clk);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL restart_state got=%0d exp=3", state); end
    checks++; if (reset_game !== 1'b1) begin errors++; $display("FAIL restart_pulse got=%0d exp=1", reset_game); end
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL play_state got=%0d exp=1", state); end
    checks++; if (move_en !== 1'b1) begin errors++; $display("FAIL play_move_en got=%0d exp=1", move_en); end
    checks++; if (reset_game !== 1'b0) begin errors++; $display("FAIL restart_one_cycle got=%0d exp=0", reset_game); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL play_score_cleared got=%0d exp=0", score); end
  endtask

  task automatic test_play_score();
    int base;
    base = tick_seen;
    for (int i = 0; i < 64; i++) begin
      drive_frame(1'b1);
      if (i == 30) begin
        checks++; if (score !== 10'd0) begin errors++; $display("FAIL score_before_div got=%0d exp=0", score); end
      end
      if (i == 31) begin
        checks++; if (score !== 10'd1) begin errors++; $display("FAIL score_at_div got=%0d exp=1", score); end
      end
    end
    checks++; if (score !== 10'd2) begin errors++; $display("FAIL score_64_frames got=%0d exp=2", score); end
    checks++; if (tick_seen - base !== 64) begin errors++; $display("FAIL tick_count got=%0d exp=64", tick_seen - base); end
  endtask

  task automatic test_collision();
    @(negedge clk); col = 1'b1;
    repeat (2) @(negedge clk); col = 1'b0;
    drive_frame(1'b1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_no_crash got=%0d exp=1", state); end
    col = 1'b1;
    drive_frame(1'b1);
    col = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_state got=%0d exp=2", state); end
    checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL crash_move_en got=%0d exp=0", move_en); end
    checks++; if (flash !== 1'b1) begin errors++; $display("FAIL crash_flash_entry got=%0d exp=1", flash); end
  endtask

  task automatic test_crash();
    logic [2:0] exp_flash;
    exp_flash = 3'b001;  // after edges 1,2,3 (LSB first): 1,0,0
    for (int i = 0; i < 3; i++) begin
      drive_frame(1'b0);
      checks++; if (flash !== exp_flash[i]) begin errors++; $display("FAIL crash_flash_%0d got=%0d exp=%0d", i + 1, flash, exp_flash[i]); end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_hold_%0d got=%0d exp=2", i + 1, state); end
      if (i == 0) pulse_start();
    end
    drive_frame(1'b0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL crash_to_idle got=%0d exp=0", state); end
    checks++; if (flash !== 1'b0) begin errors++; $display("FAIL idle_flash got=%0d exp=0", flash); end
    checks++; if (score !== 10'd2) begin errors++; $display("FAIL score_retained got=%0d exp=2", score); end
    drive_frame(1'b0);
    checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL idle_move_en got=%0d exp=0", move_en); end
  endtask

  task automatic test_grace();
    pulse_start();
    repeat (3) @(negedge clk);
    col = 1'b1;
    drive_frame(1'b1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL grace_first_edge got=%0d exp=1", state); end
    drive_frame(1'b1);
    col = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL grace_second_edge got=%0d exp=2", state); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL grace_score got=%0d exp=0", score); end
    repeat (4) drive_frame(1'b0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL grace_back_idle got=%0d exp=0", state); end
  endtask

  task automatic test_saturate();
    @(negedge clk); s_rst_n = 1'b1;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_state !== 2'd1) begin errors++; $display("FAIL sat_play got=%0d exp=1", s_state); end
    repeat (998) sat_frame();
    checks++; if (s_score !== 10'd998) begin errors++; $display("FAIL sat_998 got=%0d exp=998", s_score); end
    sat_frame();
    checks++; if (s_score !== 10'd999) begin errors++; $display("FAIL sat_999 got=%0d exp=999", s_score); end
    repeat (32) sat_frame();
    checks++; if (s_score !== 10'd999) begin errors++; $display("FAIL sat_hold got=%0d exp=999", s_score); end
    // Asynchronous reset mid-PLAY, checked before any clock edge.
    @(negedge clk);
    #2 s_rst_n = 1'b0;
    #1;
    checks++; if (s_state !== 2'd0) begin errors++; $display("FAIL async_rst_state got=%0d exp=0", s_state); end
    checks++; if ({s_tick, s_move_en, s_reset_game, s_flash} !== 4'b0) begin errors++; $display("FAIL async_rst_flags got=%b exp=0000", {s_tick, s_move_en, s_reset_game, s_flash}); end
    checks++; if (s_score !== 10'd0) begin errors++; $display("FAIL async_rst_score got=%0d exp=0", s_score); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_play_score();
    test_collision();
    test_crash();
    test_grace();
    test_saturate();
    repeat (4) @(negedge clk);
    checks++; if (exp_tick.size() !== 0) begin errors++; $display("FAIL missing_ticks got=%0d pending exp=0", exp_tick.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The module SHALL provide parameter SCORE_DIV, default 32, meaning PLAY frames per score increment.
REQ-002 The module SHALL provide parameter CRASH_FRAMES, default 120, meaning frames spent in CRASH before returning to IDLE.
REQ-003 The module SHALL provide parameter FLASH_DIV, default 8, meaning frames per oFlash toggle during CRASH.
REQ-004 iVGA_CLK  input  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-005 iRST_n  input  1  reset, asynchronous, active-low.
REQ-006 iVS  input  1  vertical sync from vga_sync, active-low pulse, synchronous to iVGA_CLK.
REQ-007 iStart  input  1  start request, active-high level, synchronous to iVGA_CLK.
REQ-008 iCollision  input  1  collision flag from collision_detection, active-high level.
REQ-009 oFrameTick  output  1  one-cycle pulse per frame, emitted only in PLAY.
REQ-010 oMoveEn  output  1  high while in PLAY; gates car and obstacle motion.
REQ-011 oResetGame  output  1  one-cycle pulse that resets car and obstacle positions.
REQ-012 oState  output  2  current state: IDLE=0, PLAY=1, CRASH=2, RESTART=3.
REQ-013 oScore  output  10  score, binary, saturating at 999.
REQ-014 oFlash  output  1  crash blink flag for the drawer.

Function
REQ-015 A frame edge SHALL be detected in the cycle after iVS is registered low, when the previous registered value was high, giving a 2-cycle latency from the iVS falling edge.
REQ-016 A start edge SHALL be a rising edge of registered iStart; a held iStart SHALL NOT produce repeat edges.
REQ-017 In IDLE, a start edge SHALL move the FSM to RESTART; all other inputs are ignored.
REQ-018 RESTART SHALL last exactly one cycle with oResetGame=1, clear oScore and the score divider, arm a one-frame collision grace, then move to PLAY.
REQ-019 In PLAY, oFrameTick SHALL pulse for one cycle on each frame edge.
REQ-020 In PLAY, iCollision SHALL be evaluated only on frame-edge cycles; mid-frame collision glitches SHALL be ignored.
REQ-021 The first frame edge after RESTART SHALL clear the grace flag and ignore iCollision.
REQ-022 In PLAY, a frame edge with iCollision=1 and no grace SHALL move the FSM to CRASH and load the crash counter with CRASH_FRAMES-1; oFrameTick SHALL still pulse in that cycle.
REQ-023 In PLAY, each non-crash frame edge SHALL advance the score divider; the SCORE_DIV-th edge SHALL reset the divider and increment oScore, holding it at 999 once reached.
REQ-024 In CRASH, each frame edge SHALL decrement the crash counter; a frame edge with the counter at 0 SHALL move the FSM to IDLE.
REQ-025 In CRASH, oFlash SHALL toggle every FLASH_DIV frame edges starting from 1 on entry; oFlash SHALL be 0 in all other states.
REQ-026 Start edges in PLAY, CRASH or RESTART SHALL be ignored.
REQ-027 oScore SHALL hold its value in CRASH and IDLE until the next RESTART.
REQ-028 oFrameTick and oMoveEn SHALL be 0 outside PLAY.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While iRST_n=0, the FSM SHALL enter IDLE immediately, including mid-PLAY or mid-CRASH.
REQ-031 While iRST_n=0, all outputs, counters, the grace flag and the registered iStart SHALL be 0.
REQ-032 While iRST_n=0, the registered iVS SHALL be 1, so no false frame edge occurs on release.

Structure
REQ-033 Shared package game_pkg SHALL hold the state encoding constants, the score saturation value 999 and the default parameter values.
REQ-034 iVS registration and frame-edge detection SHALL live in sub-module frame_tick_gen, instantiated once.

Verification
REQ-035 Reset; pulse iStart -> RESTART for 1 cycle with oResetGame=1, then oState=1 and oMoveEn=1.
REQ-036 PLAY with iCollision=0 for 64 frames, SCORE_DIV=32 -> oScore=2; exactly 64 oFrameTick pulses, each 2 cycles after an iVS falling edge.
REQ-037 Assert iCollision mid-frame and drop it before the frame edge -> no CRASH; hold it across the frame edge -> oState=2, oMoveEn=0, oFlash=1.
REQ-038 CRASH_FRAMES=4, FLASH_DIV=2 -> oFlash sequence 1,1,0,0 over frames; IDLE after the 4th frame edge in CRASH; oScore retained; iStart during CRASH ignored.
REQ-039 iCollision=1 at the first frame edge after RESTART -> remains in PLAY; iCollision=1 at the second frame edge -> CRASH.
REQ-040 Force oScore to 999 and run 32 more frames -> oScore stays 999; assert iRST_n=0 mid-PLAY -> oState=0 and all outputs 0 immediately.
